simon_decrypt: RTL and testbench

- Iterative Simon 32/64 decryption core; the inverse datapath of the Simon encryption core.
- Consumes the 32 round keys produced by the `simon_key` expansion block (`key[0]` is the first encryption round key).
- Accepts one 32-bit ciphertext per handshake, applies the 32 inverse rounds one per cycle with keys `key[31]` down to `key[0]`, and returns the plaintext on a valid/ready output port.

---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_round.sv | 22 ++
 rtl/simon_decrypt.sv | 92 +++++++++
 tb/tb_simon_decrypt.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon 32/64 definitions: sizes, round-key array type, round function
// and the constants consumed by the key expansion.
package simon_pkg;
    localparam int WORD      = 16;
    localparam int ROUNDS    = 32;
    localparam int KEY_WORDS = 4;

    typedef logic [ROUNDS-1:0][WORD-1:0] rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // z0 sequence packed LSB-first (bit j feeds expansion step j+4), c = 2^n - 4.
    localparam logic [63:0]     Z0 = 64'h19C3522FB386A45F;
    localparam logic [WORD-1:0] C  = 16'hFFFC;

    function automatic logic [WORD-1:0] simon_f(input logic [WORD-1:0] v);
        logic [WORD-1:0] r1, r2, r8;
        r1 = {v[WORD-2:0], v[WORD-1]};
        r2 = {v[WORD-3:0], v[WORD-1:WORD-2]};
        r8 = {v[WORD-9:0], v[WORD-1:WORD-8]};
        return (r1 & r8) ^ r2;
    endfunction
endpackage

// File: rtl/simon_round.sv
// One combinational Simon round; DIR=0 is the forward round, DIR=1 its inverse.
module simon_round
    import simon_pkg::*;
#(
    parameter bit DIR = 1'b0
) (
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic [WORD-1:0] k,
    output logic [WORD-1:0] x_next,
    output logic [WORD-1:0] y_next
);
    generate
        if (DIR == 1'b0) begin : g_enc
            assign x_next = y ^ simon_f(x) ^ k;
            assign y_next = x;
        end else begin : g_dec
            assign x_next = y;
            assign y_next = x ^ simon_f(y) ^ k;
        end
    endgenerate
endmodule

// File: rtl/simon_decrypt.sv
// Iterative Simon 32/64 decryption core: one inverse round per cycle, keys applied
// from the last encryption round key down to the first.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for a ciphertext, in_ready high
//   ST_RUN  | applying inverse round with kreg[rc], rc counting down to 0
//   ST_DONE | plaintext held on the output until out_ready
module simon_decrypt #(
    parameter int ROUNDS = 32,
    parameter int WORD   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*WORD-1:0]            ciphertext,
    input  logic [ROUNDS-1:0][WORD-1:0]  key,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*WORD-1:0]            plaintext,
    output logic                         busy
);
    import simon_pkg::*;

    localparam int RC_W = $clog2(ROUNDS);

    state_t                     state, state_next;
    logic [WORD-1:0]            x, y, x_rnd, y_rnd;
    logic [ROUNDS-1:0][WORD-1:0] kreg;
    logic [RC_W-1:0]            rc;
    logic                       accept, last_round;

    assign accept     = in_valid && (state == ST_IDLE);
    assign last_round = (rc == '0);

    simon_round #(.DIR(1'b1)) u_round (
        .x      (x),
        .y      (y),
        .k      (kreg[rc]),
        .x_next (x_rnd),
        .y_next (y_rnd)
    );

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_round) state_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            rc    <= '0;
            x     <= '0;
            y     <= '0;
            kreg  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                x    <= ciphertext[2*WORD-1:WORD];
                y    <= ciphertext[WORD-1:0];
                kreg <= key;
                rc   <= RC_W'(ROUNDS - 1);
            end else if (state == ST_RUN) begin
                x <= x_rnd;
                y <= y_rnd;
                // rc parks at zero once the final round is applied
                if (!last_round) rc <= rc - RC_W'(1);
            end
        end
    end

    assign plaintext = {x, y};
endmodule

// File: tb/tb_simon_decrypt.sv
// Directed and round-trip checks for simon_decrypt against an independent Simon model.
`timescale 1ns/1ps
module tb_simon_decrypt;
    typedef logic [31:0][15:0] keys_t;

    logic        clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] ciphertext, plaintext;
    keys_t       key;
    keys_t       kat_keys;

    int total, bad;
    int cyc, acc_count, acc_cyc, out_count, out_cyc, valid_cycles;

    simon_decrypt dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_count <= acc_count + 1;
            acc_cyc   <= cyc;
        end
        if (!rst && out_valid && out_ready) begin
            out_count <= out_count + 1;
            out_cyc   <= cyc;
        end
        if (!rst && out_valid) valid_cycles <= valid_cycles + 1;
    end

    function automatic logic [15:0] rotl(input logic [15:0] v, input int s);
        return (v << s) | (v >> (16 - s));
    endfunction

    function automatic logic [15:0] f_model(input logic [15:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic keys_t expand(input logic [15:0] k3, k2, k1, k0);
        keys_t       k;
        logic [63:0] z;
        logic [15:0] t;
        z = 64'h19C3522FB386A45F;
        k = '0;
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        for (int i = 4; i < 32; i++) begin
            t = rotl(k[i-1], 13) ^ k[i-3];
            t = t ^ rotl(t, 15);
            k[i] = ~k[i-4] ^ t ^ {15'd0, z[i-4]} ^ 16'd3;
        end
        return k;
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] pt, input keys_t k);
        logic [15:0] x, y, t;
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ f_model(x) ^ k[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic send_block(input logic [31:0] ct, input keys_t k, output bit ok);
        int n;
        n = acc_count;
        ciphertext = ct;
        key        = k;
        in_valid   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (acc_count != n) break;
        end
        in_valid = 1'b0;
        ok = (acc_count != n);
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) begin
                ok  = 1'b1;
                lat = cyc - 1 - acc_cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; ciphertext = '0; key = '0;
        repeat (3) @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (plaintext !== 32'h0) begin bad++; $display("FAIL rst_plaintext: got %h want 0", plaintext); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_known_answer();
        bit ok; int lat; int n_out;
        out_ready = 1'b1;
        send_block(32'hc69be9bb, kat_keys, ok);
        total++; if (!ok) begin bad++; $display("FAIL kat_accept: got timeout want accept"); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++;
            $display("FAIL kat_run_flags: got busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready); end
        n_out = out_count;
        wait_valid(lat, ok);
        total++; if (!ok || lat != 32) begin bad++; $display("FAIL kat_latency: got %0d want 32", lat); end
        total++; if (plaintext !== 32'h65656877) begin bad++; $display("FAIL kat_pt: got %h want 65656877", plaintext); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count != n_out + 1) begin bad++;
            $display("FAIL kat_handshake: got out_valid=%b in_ready=%b hs=%0d want 0 1 %0d",
                     out_valid, in_ready, out_count - n_out, 1); end
    endtask

    task automatic test_key_capture();
        bit ok; int lat;
        out_ready = 1'b1;
        send_block(32'hc69be9bb, kat_keys, ok);
        key = {32{16'hFFFF}};
        ciphertext = 32'h0;
        wait_valid(lat, ok);
        total++; if (!ok || lat != 32) begin bad++; $display("FAIL keycap_latency: got %0d want 32", lat); end
        total++; if (plaintext !== 32'h65656877) begin bad++; $display("FAIL keycap_pt: got %h want 65656877", plaintext); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bit ok; int lat; int n_acc, n_out;
        bit pt_bad, rdy_bad, ov_bad;
        keys_t       k2;
        logic [31:0] pt2;
        k2  = expand(16'h0123, 16'h4567, 16'h89ab, 16'hcdef);
        pt2 = 32'hdead_beef;
        out_ready = 1'b0;
        send_block(32'hc69be9bb, kat_keys, ok);
        ciphertext = encrypt(pt2, k2);
        key = k2;
        in_valid = 1'b1;
        wait_valid(lat, ok);
        total++; if (!ok || lat != 32) begin bad++; $display("FAIL bp_latency: got %0d want 32", lat); end
        n_acc = acc_count; n_out = out_count;
        pt_bad = 0; rdy_bad = 0; ov_bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (plaintext !== 32'h65656877) pt_bad = 1;
            if (in_ready !== 1'b0) rdy_bad = 1;
            if (out_valid !== 1'b1) ov_bad = 1;
            @(posedge clk); #1;
        end
        total++; if (pt_bad) begin bad++; $display("FAIL bp_pt_stable: got unstable want 65656877"); end
        total++; if (rdy_bad) begin bad++; $display("FAIL bp_in_ready: got 1 want 0"); end
        total++; if (ov_bad) begin bad++; $display("FAIL bp_out_valid_held: got drop want 1"); end
        total++; if (acc_count != n_acc) begin bad++; $display("FAIL bp_no_accept: got %0d accepts want 0", acc_count - n_acc); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_count != n_out + 1) begin bad++; $display("FAIL bp_one_handshake: got %0d want 1", out_count - n_out); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (acc_count != n_acc + 1 || acc_cyc != out_cyc + 1) begin bad++;
            $display("FAIL bp_next_accept: got n=%0d gap=%0d want n=1 gap=1", acc_count - n_acc, acc_cyc - out_cyc); end
        total++; if (out_count != n_out + 1) begin bad++; $display("FAIL bp_handshake_total: got %0d want 1", out_count - n_out); end
        wait_valid(lat, ok);
        total++; if (!ok || plaintext !== pt2) begin bad++; $display("FAIL bp_second_pt: got %h want %h", plaintext, pt2); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok; int lat; int n;
        keys_t       kb;
        logic [31:0] ptb;
        kb  = expand(16'hffff, 16'h0000, 16'haaaa, 16'h5555);
        ptb = 32'h0000_0001;
        out_ready = 1'b1;
        n = acc_count;
        send_block(32'hc69be9bb, kat_keys, ok);
        ciphertext = encrypt(ptb, kb);
        key = kb;
        in_valid = 1'b1;
        wait_valid(lat, ok);
        total++; if (acc_count != n + 1) begin bad++; $display("FAIL b2b_run_accepts: got %0d want 1", acc_count - n); end
        total++; if (!ok || plaintext !== 32'h65656877) begin bad++; $display("FAIL b2b_first_pt: got %h want 65656877", plaintext); end
        @(posedge clk); #1;
        total++; if (acc_count != n + 1) begin bad++; $display("FAIL b2b_hs_no_accept: got %0d want 1", acc_count - n); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (acc_count != n + 2 || acc_cyc != out_cyc + 1) begin bad++;
            $display("FAIL b2b_first_idle_accept: got n=%0d gap=%0d want n=2 gap=1", acc_count - n, acc_cyc - out_cyc); end
        wait_valid(lat, ok);
        total++; if (!ok || plaintext !== ptb) begin bad++; $display("FAIL b2b_second_pt: got %h want %h", plaintext, ptb); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; int v0;
        out_ready = 1'b1;
        send_block(32'hc69be9bb, kat_keys, ok);
        v0 = valid_cycles;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (plaintext !== 32'h0) begin bad++; $display("FAIL midrst_plaintext: got %h want 0", plaintext); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        total++; if (valid_cycles != v0) begin bad++; $display("FAIL midrst_no_output: got %0d valid cycles want 0", valid_cycles - v0); end
        send_block(32'hc69be9bb, kat_keys, ok);
        wait_valid(lat, ok);
        total++; if (!ok || lat != 32 || plaintext !== 32'h65656877) begin bad++;
            $display("FAIL midrst_after: got %h lat=%0d want 65656877 lat=32", plaintext, lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_trip(input int nblk);
        bit ok; int lat; int n; int prev;
        logic [31:0] r0, r1, pt;
        keys_t       k;
        out_ready = 1'b1;
        prev = 0;
        for (int b = 0; b < nblk; b++) begin
            r0 = $urandom; r1 = $urandom; pt = $urandom;
            k  = expand(r0[31:16], r0[15:0], r1[31:16], r1[15:0]);
            ciphertext = encrypt(pt, k);
            key = k;
            in_valid = 1'b1;
            n = acc_count;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (acc_count != n) break;
            end
            if (acc_count == n) begin
                total++; bad++; $display("FAIL rt_accept_timeout: got none want accept at block %0d", b);
                break;
            end
            if (b > 0) begin
                total++; if (acc_cyc - prev != 34) begin bad++;
                    $display("FAIL rt_spacing: got %0d want 34 at block %0d", acc_cyc - prev, b); end
            end
            prev = acc_cyc;
            wait_valid(lat, ok);
            total++; if (!ok || plaintext !== pt) begin bad++;
                $display("FAIL rt_pt: got %h want %h at block %0d", plaintext, pt, b); end
            if (!ok) break;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0; bad = 0;
        kat_keys = expand(16'h1918, 16'h1110, 16'h0908, 16'h0100);
        test_reset();
        test_known_answer();
        test_key_capture();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_round_trip(1000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
